// File: rtl/vec_alu_pkg.sv
// Shared definitions for the lane-parallel vector ALU.
// Opcode encodings are fixed by the instruction decoder and must not be renumbered.
package vec_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MOV = 3'b010,
    OP_MUL = 3'b011,
    OP_DIV = 3'b100
  } vec_op_t;

endpackage

// File: rtl/vec_alu_lane.sv
// One unsigned ALU lane: purely combinational, result is WIDTH bits, wrap-around arithmetic.
// Reserved opcodes produce zero; divide by zero returns all ones.
module vec_alu_lane
  import vec_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_ADD: y = a + b;
      OP_SUB: y = a - b;
      OP_MOV: y = a;
      // Only the low WIDTH bits of the product are kept.
      OP_MUL: y = a * b;
      OP_DIV: y = (b == '0) ? '1 : (a / b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/vec_alu.sv
// Vector ALU top: LANES independent lanes feeding a single result register.
// One-cycle latency, one operation per cycle, synchronous active-high reset.
module vec_alu
  import vec_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LANES = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [LANES-1:0][WIDTH-1:0]   A,
  input  logic [LANES-1:0][WIDTH-1:0]   B,
  input  logic [2:0]                    Operation,
  output logic [LANES-1:0][WIDTH-1:0]   Result
);

  logic [LANES-1:0][WIDTH-1:0] w_lane_y;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    vec_alu_lane #(
      .WIDTH(WIDTH)
    ) u_lane (
      .a  (A[g]),
      .b  (B[g]),
      .op (Operation),
      .y  (w_lane_y[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      Result <= '0;
    end else begin
      Result <= w_lane_y;
    end
  end

endmodule

// File: tb/tb_vec_alu.sv
// Directed bench for vec_alu: hand-computed vectors across all 16 lanes per scenario.
module tb_vec_alu;

  typedef logic [7:0] vec_t [16];

  logic                clk;
  logic                reset;
  logic [15:0][7:0]    A;
  logic [15:0][7:0]    B;
  logic [2:0]          Operation;
  logic [15:0][7:0]    Result;

  int checks;
  int errors;

  vec_alu #(
    .WIDTH(8),
    .LANES(16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .A         (A),
    .B         (B),
    .Operation (Operation),
    .Result    (Result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive on the falling edge, then sample 1 ns after the next rising edge.
  task automatic drive(input vec_t va, input vec_t vb, input logic [2:0] op, input logic rst);
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      A[i] = va[i];
      B[i] = vb[i];
    end
    Operation = op;
    reset     = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    vec_t va, vb;
    va = '{200, 254, 251, 200, 5, 10, 100, 15, 255, 128, 0, 1, 77, 90, 33, 255};
    vb = '{100, 1, 1, 45, 25, 1, 2, 10, 1, 128, 0, 254, 23, 10, 66, 255};
    drive(va, vb, 3'b000, 1'b1);
    drive(va, vb, 3'b000, 1'b1);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (Result[i] !== 8'd0) begin
        errors++;
        $display("FAIL reset lane %0d: got %0d expected 0", i, Result[i]);
      end
    end
  endtask

  task automatic test_add();
    vec_t va, vb, ve;
    va = '{200, 254, 251, 200, 5, 10, 100, 15, 255, 128, 0, 1, 77, 90, 33, 255};
    vb = '{100, 1, 1, 45, 25, 1, 2, 10, 1, 128, 0, 254, 23, 10, 66, 255};
    ve = '{44, 255, 252, 245, 30, 11, 102, 25, 0, 0, 0, 255, 100, 100, 99, 254};
    drive(va, vb, 3'b000, 1'b0);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (Result[i] !== ve[i]) begin
        errors++;
        $display("FAIL add lane %0d: got %0d expected %0d", i, Result[i], ve[i]);
      end
    end
  endtask

  task automatic test_sub();
    vec_t va, vb, ve;
    va = '{100, 255, 251, 200, 25, 10, 100, 15, 3, 0, 10, 128, 255, 1, 50, 7};
    vb = '{100, 55, 1, 45, 5, 1, 2, 10, 5, 1, 10, 129, 0, 2, 20, 8};
    ve = '{0, 200, 250, 155, 20, 9, 98, 5, 254, 255, 0, 255, 255, 255, 30, 255};
    drive(va, vb, 3'b001, 1'b0);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (Result[i] !== ve[i]) begin
        errors++;
        $display("FAIL sub lane %0d: got %0d expected %0d", i, Result[i], ve[i]);
      end
    end
  endtask

  task automatic test_mov();
    vec_t va, vb, ve;
    va = '{100, 255, 251, 200, 25, 10, 100, 15, 1, 2, 4, 8, 16, 32, 64, 128};
    vb = '{170, 170, 170, 170, 170, 170, 170, 170, 3, 99, 0, 255, 7, 1, 2, 44};
    ve = '{100, 255, 251, 200, 25, 10, 100, 15, 1, 2, 4, 8, 16, 32, 64, 128};
    drive(va, vb, 3'b010, 1'b0);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (Result[i] !== ve[i]) begin
        errors++;
        $display("FAIL mov lane %0d: got %0d expected %0d", i, Result[i], ve[i]);
      end
    end
  endtask

  task automatic test_mul();
    vec_t va, vb, ve;
    va = '{2, 6, 10, 15, 4, 8, 25, 50, 16, 255, 0, 128, 17, 3, 255, 100};
    vb = '{2, 2, 20, 2, 5, 5, 2, 2, 20, 255, 77, 2, 15, 85, 1, 3};
    ve = '{4, 12, 200, 30, 20, 40, 50, 100, 64, 1, 0, 0, 255, 255, 255, 44};
    drive(va, vb, 3'b011, 1'b0);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (Result[i] !== ve[i]) begin
        errors++;
        $display("FAIL mul lane %0d: got %0d expected %0d", i, Result[i], ve[i]);
      end
    end
  endtask

  task automatic test_div();
    vec_t va, vb, ve;
    va = '{2, 6, 10, 15, 200, 8, 25, 50, 9, 0, 255, 255, 7, 100, 1, 0};
    vb = '{2, 2, 2, 2, 100, 4, 5, 2, 0, 0, 1, 255, 8, 3, 255, 5};
    ve = '{1, 3, 5, 7, 2, 2, 5, 25, 255, 255, 255, 1, 0, 33, 0, 0};
    drive(va, vb, 3'b100, 1'b0);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (Result[i] !== ve[i]) begin
        errors++;
        $display("FAIL div lane %0d: got %0d expected %0d", i, Result[i], ve[i]);
      end
    end
  endtask

  task automatic test_reserved();
    vec_t va, vb;
    logic [2:0] op;
    va = '{200, 254, 251, 200, 5, 10, 100, 15, 255, 128, 0, 1, 77, 90, 33, 255};
    vb = '{100, 1, 1, 45, 25, 1, 2, 10, 1, 128, 0, 254, 23, 10, 66, 255};
    for (int k = 5; k < 8; k++) begin
      op = 3'(k);
      drive(va, vb, op, 1'b0);
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (Result[i] !== 8'd0) begin
          errors++;
          $display("FAIL reserved op %0d lane %0d: got %0d expected 0", k, i, Result[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_stream();
    vec_t va, vb, ve_add, vm, vn;
    va = '{200, 254, 251, 200, 5, 10, 100, 15, 255, 128, 0, 1, 77, 90, 33, 255};
    vb = '{100, 1, 1, 45, 25, 1, 2, 10, 1, 128, 0, 254, 23, 10, 66, 255};
    ve_add = '{44, 255, 252, 245, 30, 11, 102, 25, 0, 0, 0, 255, 100, 100, 99, 254};
    vm = '{2, 6, 10, 15, 4, 8, 25, 50, 16, 255, 0, 128, 17, 3, 255, 100};
    vn = '{2, 2, 20, 2, 5, 5, 2, 2, 20, 255, 77, 2, 15, 85, 1, 3};
    drive(va, vb, 3'b000, 1'b0);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (Result[i] !== ve_add[i]) begin
        errors++;
        $display("FAIL midrst pre lane %0d: got %0d expected %0d", i, Result[i], ve_add[i]);
      end
    end
    drive(vm, vn, 3'b011, 1'b1);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (Result[i] !== 8'd0) begin
        errors++;
        $display("FAIL midrst during lane %0d: got %0d expected 0", i, Result[i]);
      end
    end
    drive(va, vb, 3'b000, 1'b0);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (Result[i] !== ve_add[i]) begin
        errors++;
        $display("FAIL midrst post lane %0d: got %0d expected %0d", i, Result[i], ve_add[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t va, vb, ve_sub;
    va = '{200, 254, 251, 200, 5, 10, 100, 15, 255, 128, 0, 1, 77, 90, 33, 255};
    vb = '{100, 1, 1, 45, 25, 1, 2, 10, 1, 128, 0, 254, 23, 10, 66, 255};
    ve_sub = '{100, 253, 250, 155, 236, 9, 98, 5, 254, 0, 0, 3, 54, 80, 223, 0};
    drive(va, vb, 3'b001, 1'b0);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (Result[i] !== ve_sub[i]) begin
        errors++;
        $display("FAIL b2b sub lane %0d: got %0d expected %0d", i, Result[i], ve_sub[i]);
      end
    end
    // Glitch the inputs mid-cycle; only the value present at the edge may count.
    @(negedge clk);
    Operation = 3'b011;
    #2;
    Operation = 3'b010;
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (Result[i] !== va[i]) begin
        errors++;
        $display("FAIL b2b mov lane %0d: got %0d expected %0d", i, Result[i], va[i]);
      end
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    A         = '0;
    B         = '0;
    Operation = 3'b000;
    test_reset();
    test_add();
    test_sub();
    test_mov();
    test_mul();
    test_div();
    test_reserved();
    test_reset_mid_stream();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
